// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Opcodes, ALUOp encodings and ID/EX control types for the
//               five-stage MIPS pipeline.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       illegal;
  } id_ex_t;

  localparam ctrl_t  CTRL_NOP     = '0;
  localparam id_ex_t ID_EX_BUBBLE = '0;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
// Module      : main_decoder
// Description : Combinational opcode decode to main control signals plus an
//               unsupported-opcode flag.
// Revision    : 1.0
// ============================================================================
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule : main_decoder
`default_nettype wire

// File: rtl/id_ex_control.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_control
// Description : ID-stage control issue: opcode decode, ID/EX control register
//               with flush/stall priority, and load-use hazard detection.
//               Load-use detection is built only when LOAD_USE_HAZARD_EN is
//               defined; otherwise hazard_stall is tied low.
// Revision    : 1.0
// ============================================================================
module id_ex_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        hazard_stall,
  output logic [1:0]  ALUOp_EX,
  output logic [5:0]  FuncCode_EX,
  output logic        RegDst_EX,
  output logic        ALUSrc_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        MemtoReg_EX,
  output logic        RegWrite_EX,
  output logic        Branch_EX,
  output logic        Jump_EX,
  output logic [4:0]  Rs_EX,
  output logic [4:0]  Rt_EX,
  output logic [4:0]  Rd_EX,
  output logic        illegal_EX
);

  logic [5:0] w_opcode;
  ctrl_t      w_dec_ctrl;
  logic       w_dec_illegal;
  id_ex_t     w_issue;
  id_ex_t     r_id_ex;
  logic       w_unused_shamt;

  assign w_opcode       = Instr[31:26];
  assign w_unused_shamt = ^Instr[10:6];

  main_decoder u_main_decoder (
    .opcode  (w_opcode),
    .ctrl    (w_dec_ctrl),
    .illegal (w_dec_illegal)
  );

  // An unsupported opcode issues as a bubble that only carries the illegal flag.
  always_comb begin
    w_issue = ID_EX_BUBBLE;
    if (w_dec_illegal) begin
      w_issue.illegal = 1'b1;
    end else begin
      w_issue.ctrl  = w_dec_ctrl;
      w_issue.funct = Instr[5:0];
      w_issue.rs    = Instr[25:21];
      w_issue.rt    = Instr[20:16];
      w_issue.rd    = Instr[15:11];
    end
  end

`ifdef LOAD_USE_HAZARD_EN
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match   = (r_id_ex.rt == Instr[25:21]);
  assign w_rt_match   = (r_id_ex.rt == Instr[20:16]) && reads_rt(w_opcode);
  assign hazard_stall = r_id_ex.ctrl.mem_read && (r_id_ex.rt != 5'd0) &&
                        (w_rs_match || w_rt_match);
`else
  assign hazard_stall = 1'b0;
`endif

  // flush beats ex_stall; ex_stall beats the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_ex <= ID_EX_BUBBLE;
    end else if (flush) begin
      r_id_ex <= ID_EX_BUBBLE;
    end else if (!ex_stall) begin
      if (hazard_stall) begin
        r_id_ex <= ID_EX_BUBBLE;
      end else begin
        r_id_ex <= w_issue;
      end
    end
  end

  assign ALUOp_EX    = r_id_ex.ctrl.alu_op;
  assign FuncCode_EX = r_id_ex.funct;
  assign RegDst_EX   = r_id_ex.ctrl.reg_dst;
  assign ALUSrc_EX   = r_id_ex.ctrl.alu_src;
  assign MemRead_EX  = r_id_ex.ctrl.mem_read;
  assign MemWrite_EX = r_id_ex.ctrl.mem_write;
  assign MemtoReg_EX = r_id_ex.ctrl.mem_to_reg;
  assign RegWrite_EX = r_id_ex.ctrl.reg_write;
  assign Branch_EX   = r_id_ex.ctrl.branch;
  assign Jump_EX     = r_id_ex.ctrl.jump;
  assign Rs_EX       = r_id_ex.rs;
  assign Rt_EX       = r_id_ex.rt;
  assign Rd_EX       = r_id_ex.rd;
  assign illegal_EX  = r_id_ex.illegal;

endmodule : id_ex_control
`default_nettype wire

// File: tb/tb_id_ex_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_control
// Description : Directed self-checking bench for id_ex_control; expectations
//               follow LOAD_USE_HAZARD_EN when it is defined.
// Revision    : 1.0
// ============================================================================
module tb_id_ex_control;

`ifdef LOAD_USE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instr;
  logic        ex_stall;
  logic        flush;
  logic        hazard_stall;
  logic [1:0]  ALUOp_EX;
  logic [5:0]  FuncCode_EX;
  logic        RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX;
  logic        MemtoReg_EX, RegWrite_EX, Branch_EX, Jump_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        illegal_EX;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Instr        (Instr),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .ALUOp_EX     (ALUOp_EX),
    .FuncCode_EX  (FuncCode_EX),
    .RegDst_EX    (RegDst_EX),
    .ALUSrc_EX    (ALUSrc_EX),
    .MemRead_EX   (MemRead_EX),
    .MemWrite_EX  (MemWrite_EX),
    .MemtoReg_EX  (MemtoReg_EX),
    .RegWrite_EX  (RegWrite_EX),
    .Branch_EX    (Branch_EX),
    .Jump_EX      (Jump_EX),
    .Rs_EX        (Rs_EX),
    .Rt_EX        (Rt_EX),
    .Rd_EX        (Rd_EX),
    .illegal_EX   (illegal_EX)
  );

  // Control byte order: RegDst ALUSrc MemRead MemWrite MemtoReg RegWrite Branch Jump
  logic [31:0] obs;
  assign obs = {ALUOp_EX, FuncCode_EX, RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX,
                MemtoReg_EX, RegWrite_EX, Branch_EX, Jump_EX, Rs_EX, Rt_EX, Rd_EX,
                illegal_EX};

  function automatic logic [31:0] pk(input logic [1:0] aop, input logic [5:0] fn,
                                     input logic [7:0] c, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic il);
    return {aop, fn, c, rs, rt, rd, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_hz(input string tag, input logic exp);
    check(tag, {31'd0, hazard_stall}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] i_add, i_lw5, i_dep, i_ind, i_lw0, i_dep0, i_swd, i_addi, i_beq, i_j, i_ill;
  logic [31:0] e_add, e_lw5, e_dep, e_ind, e_lw0, e_dep0, e_swd, e_addi, e_beq, e_j, e_ill;

  initial begin
    i_add  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    i_lw5  = {6'h23, 5'd1, 5'd5, 16'd0};
    i_dep  = {6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h20};
    i_ind  = {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h20};
    i_lw0  = {6'h23, 5'd1, 5'd0, 16'd0};
    i_dep0 = {6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20};
    i_swd  = {6'h2b, 5'd1, 5'd5, 16'd4};
    i_addi = {6'h08, 5'd1, 5'd5, 16'd3};
    i_beq  = {6'h04, 5'd1, 5'd2, 16'd8};
    i_j    = {6'h02, 26'h100};
    i_ill  = 32'hffff_ffff;

    e_add  = pk(2'b10, 6'h20, 8'h84, 5'd1, 5'd2, 5'd3, 1'b0);
    e_lw5  = pk(2'b00, 6'h00, 8'h6c, 5'd1, 5'd5, 5'd0, 1'b0);
    e_dep  = pk(2'b10, 6'h20, 8'h84, 5'd5, 5'd2, 5'd6, 1'b0);
    e_ind  = pk(2'b10, 6'h20, 8'h84, 5'd1, 5'd2, 5'd6, 1'b0);
    e_lw0  = pk(2'b00, 6'h00, 8'h6c, 5'd1, 5'd0, 5'd0, 1'b0);
    e_dep0 = pk(2'b10, 6'h20, 8'h84, 5'd0, 5'd0, 5'd6, 1'b0);
    e_swd  = pk(2'b00, 6'h04, 8'h50, 5'd1, 5'd5, 5'd0, 1'b0);
    e_addi = pk(2'b00, 6'h03, 8'h44, 5'd1, 5'd5, 5'd0, 1'b0);
    e_beq  = pk(2'b01, 6'h08, 8'h02, 5'd1, 5'd2, 5'd0, 1'b0);
    e_j    = pk(2'b00, 6'h00, 8'h01, 5'd0, 5'd0, 5'd0, 1'b0);
    e_ill  = pk(2'b00, 6'h00, 8'h00, 5'd0, 5'd0, 5'd0, 1'b1);

    rst_n = 1'b0; Instr = i_add; ex_stall = 1'b0; flush = 1'b0;
    #3;
    check("reset_out", obs, 32'd0);
    check_hz("reset_hz", 1'b0);
    step();
    check("reset_hold", obs, 32'd0);
    rst_n = 1'b1;

    step();                          check("rtype", obs, e_add);
    Instr = i_lw5; step();           check("lw", obs, e_lw5);
    Instr = i_dep; #1;               check_hz("lu_hz", HZ);
    step();                          check("lu_slot", obs, HZ ? 32'd0 : e_dep);
                                     check_hz("lu_hz_drop", 1'b0);
    step();                          check("lu_issue", obs, e_dep);

    Instr = i_lw5; step();           check("lw_b", obs, e_lw5);
    Instr = i_ind;  #1;              check_hz("nodep_hz", 1'b0);
    Instr = i_addi; #1;              check_hz("addi_rt_hz", 1'b0);
    Instr = i_swd;  #1;              check_hz("sw_rt_hz", HZ);
    Instr = i_lw0;  step();          check("lw0", obs, e_lw0);
    Instr = i_dep0; #1;              check_hz("zero_reg_hz", 1'b0);
    step();                          check("dep0", obs, e_dep0);

    Instr = i_swd;  step();          check("sw", obs, e_swd);
    Instr = i_addi; step();          check("addi", obs, e_addi);
    Instr = i_j;    step();          check("jump", obs, e_j);
    Instr = i_ill;  step();          check("illegal", obs, e_ill);
    Instr = i_beq;  step();          check("beq", obs, e_beq);

    Instr = i_addi; step();          check("addi_b", obs, e_addi);
    Instr = i_beq; flush = 1'b1; ex_stall = 1'b1;
    step();                          check("flush_stall", obs, 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    Instr = i_lw5; step();           check("lw_c", obs, e_lw5);
    Instr = i_dep; ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_hold", obs, e_lw5);
      check_hz("stall_hz", HZ);
    end
    ex_stall = 1'b0;
    step();                          check("stall_rel", obs, HZ ? 32'd0 : e_dep);
    step();                          check("stall_issue", obs, e_dep);

    Instr = i_lw5; step();           check("lw_d", obs, e_lw5);
    Instr = i_dep; flush = 1'b1; #1; check_hz("flush_hz", HZ);
    step();                          check("flush_bubble", obs, 32'd0);
    flush = 1'b0;
    step();                          check("post_flush", obs, e_dep);

    #2; rst_n = 1'b0; #1;
    check("async_rst", obs, 32'd0);
    check_hz("async_rst_hz", 1'b0);
    #2; rst_n = 1'b1;
    step();                          check("post_rst", obs, e_dep);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_id_ex_control
`default_nettype wire

// File: doc/id_ex_control.md
# id_ex_control

ID-stage control issue unit for the five-stage MIPS pipeline. It decodes the IF/ID instruction opcode into the main control signals, including the 2-bit ALUOp that the EX-stage ALU control decoder expands together with the function code. It registers them into the control half of the ID/EX pipeline register. It also owns stall hold, flush bubbles and load-use hazard detection for that register.

## Interface
Parameters:
- none (widths fixed by MIPS-I)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Instr  in  32  instruction from the IF/ID register
- ex_stall  in  1  downstream freeze; ID/EX holds its contents
- flush  in  1  branch/jump squash; ID/EX loads a bubble
- hazard_stall  out  1  combinational load-use stall request to the PC and IF/ID
- ALUOp_EX  out  2  00 add, 01 sub, 10 R-type (use function code); 11 never issued
- FuncCode_EX  out  6  Instr[5:0] of the issued instruction
- RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, Branch_EX, Jump_EX  out  1 each  registered main control signals
- Rs_EX, Rt_EX, Rd_EX  out  5 each  register specifiers
- illegal_EX  out  1  the issued slot held an unsupported opcode

## Operation
Opcode decode (Instr[31:26]):
- 000000 R-type: RegDst=1, RegWrite=1, ALUOp=10.
- 100011 lw: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
- 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
- 000100 beq: Branch=1, ALUOp=01.
- 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
- 000010 j: Jump=1; all other signals 0.
- Any other opcode: bubble with illegal=1.

FuncCode is passed through for every opcode. It is meaningful only when ALUOp=10.

Bubble contents:
- All control signals 0, ALUOp=00, FuncCode=0, Rs/Rt/Rd=0.
- illegal=0, except for the illegal-opcode case above.

Next-state priority for the ID/EX control register, highest first:
1. rst_n low: bubble.
2. flush: bubble, regardless of ex_stall.
3. ex_stall: hold the current contents.
4. hazard_stall: bubble.
5. Otherwise: load the decoded Instr.

Load-use detection:
- Raw hazard = MemRead_EX and Rt_EX≠0 and either:
  - Rt_EX==Instr[25:21], or
  - Rt_EX==Instr[20:16] and the opcode reads rt (R-type, sw, beq).
- hazard_stall is the raw hazard, not gated by ex_stall or flush. Upstream ORs in ex_stall.

## Timing
- Reset: all registered outputs 0 (bubble) asynchronously. hazard_stall is 0 while in reset, because MemRead_EX is 0.
- Latency: one cycle from Instr valid to the _EX outputs.
- hazard_stall is combinational from Instr and the current _EX state. It has no internal latency.
- Load-use sequence:
  - Cycle n: a lw is in EX and a dependent instruction is in ID, so hazard_stall=1 and a bubble is inserted.
  - Cycle n+1: MemRead_EX=0, so hazard_stall drops and the dependent instruction issues.
  - Exactly one bubble per load-use.
- flush and hazard_stall in the same cycle: bubble. hazard_stall is still reported.
- ex_stall held for multiple cycles: the _EX outputs stay stable throughout. hazard_stall stays asserted while the held lw matches.
- rst_n asserted mid-operation: the in-flight slot is discarded immediately.

## Configuration
- LOAD_USE_HAZARD_EN:
  - Defined: load-use detection as specified.
  - Undefined: hazard_stall tied to 0, no hazard bubbles; software must schedule around load delays.

## Structure
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10.
  - A packed control struct type ctrl_t.
- Sub-module main_decoder: combinational opcode to ctrl_t plus the illegal flag. The top level holds the ID/EX control register, the priority mux and the hazard detection.

## Test plan
- R-type add (opcode 000000, funct 100000, rs=1, rt=2, rd=3) -> next cycle: ALUOp_EX=10, FuncCode_EX=100000, RegDst_EX=1, RegWrite_EX=1, Rd_EX=3.
- lw $5,0($1) followed by add $6,$5,$2 -> hazard_stall=1 for exactly one cycle; one bubble (all zero); then the add issues with Rs_EX=5.
- lw $5 followed by add $6,$1,$2 (no dependence); also lw $0 with a dependent on $0 -> hazard_stall stays 0 in both cases.
- beq issued while flush=1 and ex_stall=1 in the same cycle -> bubble (Branch_EX=0); ex_stall alone over 3 cycles -> outputs held unchanged.
- Opcode 111111 -> illegal_EX=1 and all controls 0. rst_n pulsed low mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.
- With LOAD_USE_HAZARD_EN undefined, repeat the load-use scenario -> hazard_stall=0 and the add issues in the cycle after the lw.
